// File: rtl/card_map_writer_if.sv
// Edit-command channel between the game-control logic and card_map_writer:
// valid/ready command fields plus the done/err completion pulses.
interface card_map_writer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [4:0] cmd_x;
   logic [2:0] cmd_y;
   logic [4:0] cmd_dx;
   logic [2:0] cmd_dy;
   logic [5:0] cmd_type;
   logic       done;
   logic       err;

   // game-control side
   modport master (
      output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_dx, cmd_dy, cmd_type,
      input  cmd_ready, done, err
   );

   // board-state owner side
   modport slave (
      input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_dx, cmd_dy, cmd_type,
      output cmd_ready, done, err
   );
endinterface

// File: rtl/card_map_writer.sv
// Board state for the card renderer: ROWS x COLS slots of 6-bit card types
// plus a select bit per slot. Applies edit commands one at a time and
// exposes the whole board packed, plus a registered single-slot read port.
module card_map_writer #(
   parameter logic [5:0] EMPTY_CARD = 6'd63,
   parameter int         COLS       = 18,
   parameter int         ROWS       = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   card_map_writer_if.slave           cmd,
   output logic [ROWS*COLS*6-1:0]     map,
   output logic [ROWS*COLS-1:0]       sel_card,
   input  logic [4:0]                 rd_x,
   input  logic [2:0]                 rd_y,
   output logic [5:0]                 rd_type,
   output logic                       rd_sel
);
   localparam int N = ROWS * COLS;

   localparam logic [2:0] OP_WRITE     = 3'd0;
   localparam logic [2:0] OP_TOGGLE    = 3'd1;
   localparam logic [2:0] OP_MOVE      = 3'd2;
   localparam logic [2:0] OP_CLEAR_SEL = 3'd3;
   localparam logic [2:0] OP_CLEAR_ALL = 3'd4;

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] MOVE_WR  = 2'd1;
   localparam logic [1:0] CLR_SCAN = 2'd2;
   localparam logic [1:0] FIN      = 2'd3;

   logic [N-1:0][5:0] cards;
   logic [N-1:0]      sel;
   logic [1:0]        state;
   logic              ready;
   logic              done_q;
   logic              err_q;
   logic [7:0]        cnt;
   logic [7:0]        src_pos;
   logic [7:0]        dst_pos;
   logic              src_ok;
   logic              dst_ok;
   logic [5:0]        src_type;

   logic [7:0]        cmd_pos;
   logic [7:0]        dst_cmd_pos;
   logic [7:0]        rd_pos;
   logic              cmd_ok;
   logic              dst_cmd_ok;
   logic              rd_ok;

   // linear slot index, row-major; 8-bit arithmetic is wide enough for any input
   function automatic logic [7:0] slot_pos(input logic [4:0] x, input logic [2:0] y);
      return 8'(x) + 8'(y) * 8'(COLS);
   endfunction

   assign cmd_pos     = slot_pos(cmd.cmd_x, cmd.cmd_y);
   assign dst_cmd_pos = slot_pos(cmd.cmd_dx, cmd.cmd_dy);
   assign rd_pos      = slot_pos(rd_x, rd_y);
   assign cmd_ok      = cmd.cmd_x  < 5'(COLS);
   assign dst_cmd_ok  = cmd.cmd_dx < 5'(COLS);
   assign rd_ok       = rd_x       < 5'(COLS);

   assign map           = cards;
   assign sel_card      = sel;
   assign cmd.cmd_ready = ready;
   assign cmd.done      = done_q;
   assign cmd.err       = err_q;

   // command sequencer, board update and registered read port
   always_ff @(posedge clk) begin
      if (!rst) begin
         cards    <= {N{EMPTY_CARD}};
         sel      <= '0;
         state    <= IDLE;
         ready    <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         cnt      <= '0;
         src_pos  <= '0;
         dst_pos  <= '0;
         src_ok   <= 1'b0;
         dst_ok   <= 1'b0;
         src_type <= EMPTY_CARD;
         rd_type  <= EMPTY_CARD;
         rd_sel   <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         // reads see the board as it was before this edge's update
         rd_type <= rd_ok ? cards[rd_pos] : EMPTY_CARD;
         rd_sel  <= rd_ok ? sel[rd_pos]   : 1'b0;
         case (state)
            IDLE: begin
               ready <= 1'b1;
               if (cmd.cmd_valid && ready) begin
                  ready <= 1'b0;
                  state <= FIN;
                  done_q <= 1'b1;
                  case (cmd.cmd_op)
                     OP_WRITE: begin
                        if (cmd_ok) begin
                           cards[cmd_pos] <= cmd.cmd_type;
                           sel[cmd_pos]   <= 1'b0;
                        end else begin
                           err_q <= 1'b1;
                        end
                     end
                     OP_TOGGLE: begin
                        if (cmd_ok) sel[cmd_pos] <= ~sel[cmd_pos];
                        else        err_q <= 1'b1;
                     end
                     OP_MOVE: begin
                        // all checks deferred to MOVE_WR, which reads dst
                        done_q   <= 1'b0;
                        state    <= MOVE_WR;
                        src_pos  <= cmd_pos;
                        dst_pos  <= dst_cmd_pos;
                        src_ok   <= cmd_ok;
                        dst_ok   <= dst_cmd_ok;
                        src_type <= cmd_ok ? cards[cmd_pos] : EMPTY_CARD;
                     end
                     OP_CLEAR_SEL: sel <= '0;
                     OP_CLEAR_ALL: begin
                        done_q <= 1'b0;
                        state  <= CLR_SCAN;
                        cnt    <= '0;
                     end
                     default: err_q <= 1'b1;
                  endcase
               end
            end
            MOVE_WR: begin
               state  <= FIN;
               done_q <= 1'b1;
               if (!src_ok || !dst_ok || src_pos == dst_pos ||
                   src_type == EMPTY_CARD || cards[dst_pos] != EMPTY_CARD) begin
                  err_q <= 1'b1;
               end else begin
                  cards[dst_pos] <= src_type;
                  cards[src_pos] <= EMPTY_CARD;
                  sel[dst_pos]   <= 1'b0;
                  sel[src_pos]   <= 1'b0;
               end
            end
            CLR_SCAN: begin
               cards[cnt] <= EMPTY_CARD;
               sel[cnt]   <= 1'b0;
               cnt        <= cnt + 8'd1;
               if (cnt == 8'(N - 1)) begin
                  state  <= FIN;
                  done_q <= 1'b1;
               end
            end
            default: begin
               // FIN: done/err visible for this one cycle
               state <= IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end
endmodule
